// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute sequencer for the 8-bit-address
// accumulator CPU. Drives the C0..C15 control bus. The outputs depend only on
// registered state, so there is no combinational path from any input to ctrl.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | powered up, waiting for run
// F1      | C0  MAR<-PC
// F2      | C1  instruction read, held until mem_ready
// F3      | C2|C3|C6  IR<-MBR[15:8], MAR<-MBR[7:0], PC<-PC+1
// DEC     | no lines; branch on opcode, flags sampled here only
// RD      | C1  operand read, held until mem_ready
// LDBR    | C7  BR<-MBR
// ALU     | one ACC operation latched at DEC (C9/C10/C11/C12/C13)
// STM     | C5  MBR<-ACC
// WR      | C4  operand write, held until mem_ready
// JT      | C14 PC<-MBR[7:0]
// CLR     | C8  ACC<-0
// HALT    | halted=1, waits for run
// FAULT   | memory timeout, sticky until rst

module ctrl_sequencer #(
  parameter int OPW     = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           acc_neg,
  input  logic           acc_zero,
  input  logic           mem_ready,
  output logic [15:0]    ctrl,
  output logic           halted,
  output logic           fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_RD, S_LDBR, S_ALU,
    S_STM, S_WR, S_JT, S_CLR, S_HALT, S_FAULT
  } state_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_STORE = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_AND   = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_OR    = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_JGEZ  = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_CLR   = OPW'(8'h0A);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(8'h0B);

  // Counter wide enough to hold TIMEOUT; with TIMEOUT=0 it just saturates.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_alu;
  logic [15:0]   w_alu_nxt;
  logic          w_wait;
  logic          w_expire;

  // No two wait states are adjacent, so clearing outside them means the
  // count is always zero on entry to F2/RD/WR.
  assign w_wait   = (r_state == S_F2) || (r_state == S_RD) || (r_state == S_WR);
  assign w_expire = (TIMEOUT > 0) && w_wait && !mem_ready && (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Memory wait counter: counts cycles without mem_ready, saturating.
  always_ff @(posedge clk) begin
    if (rst || !w_wait)                     r_cnt <= '0;
    else if (!mem_ready && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  // ACC operation chosen at DEC, so a later opcode change cannot alter it.
  always_ff @(posedge clk) begin
    if (rst)                   r_alu <= '0;
    else if (r_state == S_DEC) r_alu <= w_alu_nxt;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_alu_nxt   = 16'h0000;
    ctrl        = 16'h0000;
    halted      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_state_nxt = S_F1;
      S_F1: begin
        ctrl        = 16'h0001;
        w_state_nxt = S_F2;
      end
      S_F2: begin
        ctrl = 16'h0002;
        if (mem_ready)     w_state_nxt = S_F3;
        else if (w_expire) w_state_nxt = S_FAULT;
      end
      S_F3: begin
        ctrl        = 16'h004C;
        w_state_nxt = S_DEC;
      end
      S_DEC: begin
        w_state_nxt = S_F1;
        case (opcode)
          OP_LOAD:  begin w_state_nxt = S_RD; w_alu_nxt = 16'h0800; end
          OP_ADD:   begin w_state_nxt = S_RD; w_alu_nxt = 16'h0200; end
          OP_SUB:   begin w_state_nxt = S_RD; w_alu_nxt = 16'h0400; end
          OP_AND:   begin w_state_nxt = S_RD; w_alu_nxt = 16'h1000; end
          OP_OR:    begin w_state_nxt = S_RD; w_alu_nxt = 16'h2000; end
          OP_STORE: w_state_nxt = S_STM;
          OP_JMP:   w_state_nxt = S_JT;
          OP_JGEZ:  if (!acc_neg) w_state_nxt = S_JT;
          OP_JZ:    if (acc_zero) w_state_nxt = S_JT;
          OP_CLR:   w_state_nxt = S_CLR;
          OP_HALT:  w_state_nxt = S_HALT;
          default:  w_state_nxt = S_F1;
        endcase
      end
      S_RD: begin
        ctrl = 16'h0002;
        if (mem_ready)     w_state_nxt = S_LDBR;
        else if (w_expire) w_state_nxt = S_FAULT;
      end
      S_LDBR: begin
        ctrl        = 16'h0080;
        w_state_nxt = S_ALU;
      end
      S_ALU: begin
        ctrl        = r_alu;
        w_state_nxt = S_F1;
      end
      S_STM: begin
        ctrl        = 16'h0020;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        ctrl = 16'h0010;
        if (mem_ready)     w_state_nxt = S_F1;
        else if (w_expire) w_state_nxt = S_FAULT;
      end
      S_JT: begin
        ctrl        = 16'h4000;
        w_state_nxt = S_F1;
      end
      S_CLR: begin
        ctrl        = 16'h0100;
        w_state_nxt = S_F1;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) w_state_nxt = S_F1;
      end
      S_FAULT: fault = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
